// File: rtl/keypad_lock_param.sv
// Parametrised binary keypad lock: CODE_LEN-digit code, failure lockout,
// timed unlock hold and sticky security violation.
module keypad_lock_param #(
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN-1:0] CODE = 4'b1000,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter int OPEN_CYC = 1,
  localparam int DW = $clog2(CODE_LEN+1),
  localparam int FW = $clog2(MAX_FAIL+1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enbl,
  input  logic          i_zbut,
  input  logic          i_obut,
  input  logic          i_seci,
  output logic          o_lock,
  output logic          o_ulck,
  output logic          o_rsto,
  output logic          o_secv,
  output logic          o_lkout,
  output logic [DW-1:0] o_digcnt,
  output logic [FW-1:0] o_failcnt
);

  localparam int TMAX = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
  localparam int TW = $clog2(TMAX+1);
  localparam logic [DW-1:0] DIG_LAST = DW'(CODE_LEN-1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYC-1);
  localparam logic [TW-1:0] LK_LAST = TW'(LOCKOUT_CYC-1);

  typedef enum logic [2:0] {
    S_OFF, S_ENTRY, S_RSTS, S_OPEN, S_LOCKOUT, S_SECV
  } state_t;

  state_t        r_state, w_state_nx;
  logic [DW-1:0] r_digcnt, w_digcnt_nx;
  logic [FW-1:0] r_failcnt, w_failcnt_nx, w_fail_inc;
  logic [TW-1:0] r_tmr, w_tmr_nx;
  logic          r_zprev, r_oprev;
  logic          w_zrise, w_orise, w_press, w_ok, w_want;
  logic [CODE_LEN-1:0] w_code_sh;

  assign w_zrise = i_zbut & ~r_zprev;
  assign w_orise = i_obut & ~r_oprev;
  assign w_press = w_zrise | w_orise;
  // Shift the expected digit into the MSB instead of a computed index
  assign w_code_sh = CODE << r_digcnt;
  assign w_want = w_code_sh[CODE_LEN-1];
  assign w_ok = ~(w_zrise & w_orise) & (w_orise == w_want);
  assign w_fail_inc = (r_failcnt == FAIL_MAX) ? r_failcnt
                                              : r_failcnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_ENTRY;
      r_digcnt  <= '0;
      r_failcnt <= '0;
      r_tmr     <= '0;
      r_zprev   <= 1'b0;
      r_oprev   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_digcnt  <= w_digcnt_nx;
      r_failcnt <= w_failcnt_nx;
      r_tmr     <= w_tmr_nx;
      r_zprev   <= i_zbut;
      r_oprev   <= i_obut;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_digcnt_nx  = r_digcnt;
    w_failcnt_nx = r_failcnt;
    w_tmr_nx     = r_tmr;
    if (!i_enbl) begin
      w_state_nx   = S_OFF;
      w_digcnt_nx  = '0;
      w_failcnt_nx = '0;
      w_tmr_nx     = '0;
    end else if (i_seci) begin
      w_state_nx  = S_SECV;
      w_digcnt_nx = '0;
      w_tmr_nx    = '0;
    end else begin
      unique case (r_state)
        S_OFF:   w_state_nx = S_ENTRY;
        S_ENTRY: begin
          if (w_press) begin
            if (w_ok) begin
              if (r_digcnt == DIG_LAST) begin
                w_state_nx   = S_OPEN;
                w_digcnt_nx  = '0;
                w_failcnt_nx = '0;
                w_tmr_nx     = '0;
              end else begin
                w_digcnt_nx = r_digcnt + 1'b1;
              end
            end else begin
              w_digcnt_nx  = '0;
              w_failcnt_nx = w_fail_inc;
              w_tmr_nx     = '0;
              w_state_nx   = (w_fail_inc == FAIL_MAX) ? S_LOCKOUT
                                                      : S_RSTS;
            end
          end
        end
        S_RSTS:  w_state_nx = S_ENTRY;
        S_OPEN: begin
          if (r_tmr == OPEN_LAST) begin
            w_state_nx = S_RSTS;
            w_tmr_nx   = '0;
          end else begin
            w_tmr_nx = r_tmr + 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (r_tmr == LK_LAST) begin
            w_state_nx   = S_RSTS;
            w_tmr_nx     = '0;
            w_failcnt_nx = '0;
          end else begin
            w_tmr_nx = r_tmr + 1'b1;
          end
        end
        S_SECV:  w_state_nx = S_SECV;
        default: w_state_nx = S_ENTRY;
      endcase
    end
  end

  assign o_lock    = (r_state != S_OPEN);
  assign o_ulck    = (r_state == S_OPEN);
  assign o_rsto    = (r_state == S_RSTS);
  assign o_secv    = (r_state == S_SECV);
  assign o_lkout   = (r_state == S_LOCKOUT);
  assign o_digcnt  = r_digcnt;
  assign o_failcnt = r_failcnt;

endmodule

// File: tb/tb_keypad_lock_param.sv
// Scoreboard bench for keypad_lock_param: default build (A) and a
// 6-digit / 3-cycle-open build (B) share one stimulus bus.
module tb_keypad_lock_param;

  logic clk = 1'b0;
  logic rst = 1'b1, enbl = 1'b1, zb = 1'b0, ob = 1'b0, seci = 1'b0;

  logic a_lock, a_ulck, a_rsto, a_secv, a_lkout;
  logic [2:0] a_dig;
  logic [1:0] a_fail;
  logic b_lock, b_ulck, b_rsto, b_secv, b_lkout;
  logic [2:0] b_dig;
  logic [1:0] b_fail;

  int n_vec = 0;
  int n_err = 0;

  // stimulus word: {rst, enbl, zbut, obut, seci}
  localparam logic [4:0] IDLE = 5'b01000;
  localparam logic [4:0] PZ   = 5'b01100;
  localparam logic [4:0] PO   = 5'b01010;
  localparam logic [4:0] BOTH = 5'b01110;
  localparam logic [4:0] SEC  = 5'b01001;
  localparam logic [4:0] RSTV = 5'b11000;
  localparam logic [4:0] RSTZ = 5'b11100;
  localparam logic [4:0] DIS  = 5'b00000;
  localparam logic [4:0] DSEC = 5'b00001;

  logic [4:0]  sq[$];
  logic [15:0] eq[$];

  always #5 clk = ~clk;

  keypad_lock_param u_a (
    .i_clk(clk), .i_rst(rst), .i_enbl(enbl), .i_zbut(zb),
    .i_obut(ob), .i_seci(seci), .o_lock(a_lock), .o_ulck(a_ulck),
    .o_rsto(a_rsto), .o_secv(a_secv), .o_lkout(a_lkout),
    .o_digcnt(a_dig), .o_failcnt(a_fail)
  );

  keypad_lock_param #(
    .CODE_LEN(6), .CODE(6'b101101), .OPEN_CYC(3)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_enbl(enbl), .i_zbut(zb),
    .i_obut(ob), .i_seci(seci), .o_lock(b_lock), .o_ulck(b_ulck),
    .o_rsto(b_rsto), .o_secv(b_secv), .o_lkout(b_lkout),
    .o_digcnt(b_dig), .o_failcnt(b_fail)
  );

  function automatic logic [15:0] ex(bit lk, bit ul, bit rs, bit sv,
                                     bit lo, int d, int f);
    logic [2:0] d3;
    logic [1:0] f2;
    d3 = 3'(d);
    f2 = 2'(f);
    return {lk, ul, rs, sv, lo, 4'b0000, d3, 2'b00, f2};
  endfunction

  function automatic logic [15:0] e_ent(int d, int f);
    return ex(1, 0, 0, 0, 0, d, f);
  endfunction
  function automatic logic [15:0] e_rsts(int f);
    return ex(1, 0, 1, 0, 0, 0, f);
  endfunction
  function automatic logic [15:0] e_open();
    return ex(0, 1, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_lk();
    return ex(1, 0, 0, 0, 1, 0, 3);
  endfunction
  function automatic logic [15:0] e_secv(int f);
    return ex(1, 0, 0, 1, 0, 0, f);
  endfunction

  function automatic logic [15:0] obs(bit b);
    if (b)
      return {b_lock, b_ulck, b_rsto, b_secv, b_lkout, 4'b0000,
              b_dig, 2'b00, b_fail};
    return {a_lock, a_ulck, a_rsto, a_secv, a_lkout, 4'b0000,
            a_dig, 2'b00, a_fail};
  endfunction

  task automatic put(logic [4:0] s, logic [15:0] e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] got, want;
    int k = 0;
    put(RSTV, e_ent(0, 0));
    put(RSTV, e_ent(0, 0));
    put(IDLE, e_ent(0, 0));
    while (sq.size() != 0) begin
      {rst, enbl, zb, ob, seci} = sq.pop_front();
      tick();
      got = obs(0);
      want = eq.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset[%0d] got=%h want=%h", k, got, want);
      end
      k++;
    end
  endtask

  task automatic test_unlock();
    logic [15:0] got, want;
    int k = 0;
    put(PO, e_ent(1, 0)); put(IDLE, e_ent(1, 0));
    put(PZ, e_ent(2, 0)); put(IDLE, e_ent(2, 0));
    put(PZ, e_ent(3, 0)); put(IDLE, e_ent(3, 0));
    put(PZ, e_open());
    put(IDLE, e_rsts(0));
    put(IDLE, e_ent(0, 0));
    while (sq.size() != 0) begin
      {rst, enbl, zb, ob, seci} = sq.pop_front();
      tick();
      got = obs(0);
      want = eq.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL unlock[%0d] got=%h want=%h", k, got, want);
      end
      k++;
    end
  endtask

  task automatic test_wrong_then_right();
    logic [15:0] got, want;
    int k = 0;
    put(PZ, e_rsts(1)); put(IDLE, e_ent(0, 1));
    put(PO, e_ent(1, 1)); put(IDLE, e_ent(1, 1));
    put(PZ, e_ent(2, 1)); put(IDLE, e_ent(2, 1));
    put(PZ, e_ent(3, 1)); put(IDLE, e_ent(3, 1));
    put(PZ, e_open());
    put(IDLE, e_rsts(0));
    put(IDLE, e_ent(0, 0));
    while (sq.size() != 0) begin
      {rst, enbl, zb, ob, seci} = sq.pop_front();
      tick();
      got = obs(0);
      want = eq.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL retry[%0d] got=%h want=%h", k, got, want);
      end
      k++;
    end
  endtask

  task automatic test_lockout();
    logic [15:0] got, want;
    int k = 0;
    put(PZ, e_rsts(1)); put(IDLE, e_ent(0, 1));
    put(PZ, e_rsts(2)); put(IDLE, e_ent(0, 2));
    put(PZ, e_lk());
    for (int i = 0; i < 15; i++)
      put((i % 2 == 0) ? PO : IDLE, e_lk());
    put(IDLE, e_rsts(0));
    put(IDLE, e_ent(0, 0));
    while (sq.size() != 0) begin
      {rst, enbl, zb, ob, seci} = sq.pop_front();
      tick();
      got = obs(0);
      want = eq.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL lockout[%0d] got=%h want=%h", k, got, want);
      end
      k++;
    end
  endtask

  task automatic test_security();
    logic [15:0] got, want;
    int k = 0;
    put(PZ, e_rsts(1)); put(IDLE, e_ent(0, 1));
    put(PO, e_ent(1, 1)); put(IDLE, e_ent(1, 1));
    put(PZ, e_ent(2, 1)); put(IDLE, e_ent(2, 1));
    put(SEC, e_secv(1));
    put(IDLE, e_secv(1)); put(IDLE, e_secv(1));
    put(PO, e_secv(1)); put(IDLE, e_secv(1));
    put(DIS, e_ent(0, 0)); put(DSEC, e_ent(0, 0));
    put(IDLE, e_ent(0, 0));
    put(PO, e_ent(1, 0)); put(IDLE, e_ent(1, 0));
    put(SEC, e_secv(0));
    put(DIS, e_ent(0, 0)); put(IDLE, e_ent(0, 0));
    while (sq.size() != 0) begin
      {rst, enbl, zb, ob, seci} = sq.pop_front();
      tick();
      got = obs(0);
      want = eq.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL secv[%0d] got=%h want=%h", k, got, want);
      end
      k++;
    end
  endtask

  task automatic test_hold_and_both();
    logic [15:0] got, want;
    int k = 0;
    for (int i = 0; i < 5; i++) put(PO, e_ent(1, 0));
    put(IDLE, e_ent(1, 0));
    put(BOTH, e_rsts(1));
    put(IDLE, e_ent(0, 1));
    while (sq.size() != 0) begin
      {rst, enbl, zb, ob, seci} = sq.pop_front();
      tick();
      got = obs(0);
      want = eq.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL hold[%0d] got=%h want=%h", k, got, want);
      end
      k++;
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] got, want;
    int k = 0;
    put(RSTV, e_ent(0, 0));
    put(PO, e_ent(1, 0)); put(IDLE, e_ent(1, 0));
    put(PZ, e_ent(2, 0)); put(IDLE, e_ent(2, 0));
    put(PZ, e_ent(3, 0)); put(IDLE, e_ent(3, 0));
    put(RSTZ, e_ent(0, 0)); put(IDLE, e_ent(0, 0));
    put(PZ, e_rsts(1)); put(IDLE, e_ent(0, 1));
    put(PZ, e_rsts(2)); put(IDLE, e_ent(0, 2));
    put(PZ, e_lk());
    for (int i = 0; i < 3; i++) put(IDLE, e_lk());
    put(RSTV, e_ent(0, 0));
    put(IDLE, e_ent(0, 0)); put(IDLE, e_ent(0, 0));
    put(PO, e_ent(1, 0));
    while (sq.size() != 0) begin
      {rst, enbl, zb, ob, seci} = sq.pop_front();
      tick();
      got = obs(0);
      want = eq.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL rstmid[%0d] got=%h want=%h", k, got, want);
      end
      k++;
    end
  endtask

  task automatic test_param6();
    logic [15:0] got, want;
    int k = 0;
    put(RSTV, e_ent(0, 0));
    put(PO, e_ent(1, 0)); put(IDLE, e_ent(1, 0));
    put(PZ, e_ent(2, 0)); put(IDLE, e_ent(2, 0));
    put(PZ, e_rsts(1)); put(IDLE, e_ent(0, 1));
    put(PO, e_ent(1, 1)); put(IDLE, e_ent(1, 1));
    put(PZ, e_ent(2, 1)); put(IDLE, e_ent(2, 1));
    put(PO, e_ent(3, 1)); put(IDLE, e_ent(3, 1));
    put(PO, e_ent(4, 1)); put(IDLE, e_ent(4, 1));
    put(PZ, e_ent(5, 1)); put(IDLE, e_ent(5, 1));
    put(PO, e_open());
    put(IDLE, e_open()); put(IDLE, e_open());
    put(IDLE, e_rsts(0));
    put(IDLE, e_ent(0, 0));
    while (sq.size() != 0) begin
      {rst, enbl, zb, ob, seci} = sq.pop_front();
      tick();
      got = obs(1);
      want = eq.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL param6[%0d] got=%h want=%h", k, got, want);
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_then_right();
    test_lockout();
    test_security();
    test_hold_and_both();
    test_rst_mid();
    test_param6();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
